// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 raster constants and window helpers
package vga_timing_pkg;

  localparam int TICK_DIV_DEF  = 4;
  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic int span_total(input int display, input int front,
                                    input int sync, input int back);
    return display + front + sync + back;
  endfunction

  localparam int H_TOTAL_DEF = span_total(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL_DEF = span_total(V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

  // True when pos lies in [lo, lo+len-1]; used for both sync pulses.
  function automatic logic in_window(input coord_t pos, input int lo, input int len);
    return (int'(pos) >= lo) && (int'(pos) < lo + len);
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// rtl/pixel_tick_div.sv - free-running clock divider producing one-clk pixel ticks
module pixel_tick_div #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] DIV_LAST = W'(TICK_DIV - 1);

  logic [W-1:0] div_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + W'(1);
    end
  end

  assign p_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync.sv
// rtl/vga_sync.sv - VGA raster counters with registered sync, video and frame flags
module vga_sync
  import vga_timing_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic               p_tick,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               frame_start
);

  localparam int H_TOTAL = span_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = span_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  coord_t h_cnt, v_cnt;
  coord_t h_next, v_next;

  pixel_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  always_comb begin
    h_next = h_cnt;
    v_next = v_cnt;
    if (p_tick) begin
      if (h_cnt == H_LAST) begin
        h_next = '0;
        v_next = (v_cnt == V_LAST) ? '0 : v_cnt + coord_t'(1);
      end else begin
        h_next = h_cnt + coord_t'(1);
      end
    end
  end

  // Counters park at the last position so the first tick after reset lands on (0,0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      hsync       <= !in_window(h_next, H_DISPLAY + H_FRONT, H_SYNC);
      vsync       <= !in_window(v_next, V_DISPLAY + V_FRONT, V_SYNC);
      video_on    <= (int'(h_next) < H_DISPLAY) && (int'(v_next) < V_DISPLAY);
      frame_start <= p_tick && (h_next == '0) && (v_next == '0);
    end
  end

  assign pixel_x = h_cnt;
  assign pixel_y = v_cnt;

endmodule

// File: tb/tb_vga_sync.sv
// tb/tb_vga_sync.sv - randomized self-checking bench for vga_sync against an arithmetic raster model
module tb_vga_sync;

  localparam int DB = 2, HDB = 8, HFB = 2, HSB = 3, HBB = 1;
  localparam int VDB = 4, VFB = 1, VSB = 2, VBB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, reset_b;
  logic       p_tick_a, hsync_a, vsync_a, video_on_a, frame_start_a;
  logic       p_tick_b, hsync_b, vsync_b, video_on_b, frame_start_b;
  logic [9:0] pixel_x_a, pixel_y_a, pixel_x_b, pixel_y_b;
  logic [26:0] obs_a, obs_b;

  int checks = 0;
  int failures = 0;
  int ka, kb;

  localparam logic [26:0] RST_A = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd799, 10'd524};
  localparam logic [26:0] RST_B = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd13, 10'd7};

  vga_sync u_dut_a (
    .clk(clk), .reset(reset_a), .p_tick(p_tick_a), .hsync(hsync_a), .vsync(vsync_a),
    .video_on(video_on_a), .pixel_x(pixel_x_a), .pixel_y(pixel_y_a), .frame_start(frame_start_a)
  );

  vga_sync #(
    .TICK_DIV(DB), .H_DISPLAY(HDB), .H_FRONT(HFB), .H_SYNC(HSB), .H_BACK(HBB),
    .V_DISPLAY(VDB), .V_FRONT(VFB), .V_SYNC(VSB), .V_BACK(VBB)
  ) u_dut_b (
    .clk(clk), .reset(reset_b), .p_tick(p_tick_b), .hsync(hsync_b), .vsync(vsync_b),
    .video_on(video_on_b), .pixel_x(pixel_x_b), .pixel_y(pixel_y_b), .frame_start(frame_start_b)
  );

  assign obs_a = {p_tick_a, hsync_a, vsync_a, video_on_a, frame_start_a, pixel_x_a, pixel_y_a};
  assign obs_b = {p_tick_b, hsync_b, vsync_b, video_on_b, frame_start_b, pixel_x_b, pixel_y_b};

  // Clock edges since reset release; the model derives everything from this count.
  always @(posedge clk or negedge reset_a) if (!reset_a) ka <= 0; else ka <= ka + 1;
  always @(posedge clk or negedge reset_b) if (!reset_b) kb <= 0; else kb <= kb + 1;

  function automatic logic [26:0] model(input int k, input int d, input int hd, input int hf,
                                        input int hs, input int hb, input int vd, input int vf,
                                        input int vs, input int vb);
    int ht, vt, t, p, x, y;
    logic pt, hsn, vsn, von, fs;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    t  = k / d;
    if (t == 0) begin
      x = ht - 1; y = vt - 1; fs = 1'b0;
    end else begin
      p  = (t - 1) % (ht * vt);
      x  = p % ht;
      y  = p / ht;
      fs = ((k % d) == 0) && (p == 0);
    end
    pt  = ((k % d) == (d - 1));
    hsn = !((x >= hd + hf) && (x < hd + hf + hs));
    vsn = !((y >= vd + vf) && (y < vd + vf + vs));
    von = (x < hd) && (y < vd);
    return {pt, hsn, vsn, von, fs, x[9:0], y[9:0]};
  endfunction

  function automatic logic [26:0] model_a(input int k);
    return model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic logic [26:0] model_b(input int k);
    return model(k, DB, HDB, HFB, HSB, HBB, VDB, VFB, VSB, VBB);
  endfunction

  task automatic test_reset;
    reset_a = 1'b0;
    reset_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_a !== RST_A) begin
        failures++;
        $display("FAIL reset_hold_a cycle=%0d got=%h want=%h", i, obs_a, RST_A);
      end
      checks++;
      if (obs_b !== RST_B) begin
        failures++;
        $display("FAIL reset_hold_b cycle=%0d got=%h want=%h", i, obs_b, RST_B);
      end
    end
  endtask

  task automatic test_release_line;
    int hs_low, von_cnt;
    logic prev_von;
    hs_low = 0; von_cnt = 0; prev_von = 1'b0;
    @(negedge clk) reset_a = 1'b1;
    for (int c = 1; c <= 3210; c++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_a !== model_a(ka)) begin
        failures++;
        $display("FAIL line_cycle k=%0d got=%h want=%h", ka, obs_a, model_a(ka));
      end
      if (ka == 4) begin
        checks++;
        if ({pixel_x_a, pixel_y_a, video_on_a, frame_start_a, p_tick_a} !== {10'd0, 10'd0, 3'b110}) begin
          failures++;
          $display("FAIL first_tick x=%0d y=%0d von=%b fs=%b pt=%b want 0 0 1 1 0",
                   pixel_x_a, pixel_y_a, video_on_a, frame_start_a, p_tick_a);
        end
      end
      if (ka == 5) begin
        checks++;
        if (frame_start_a !== 1'b0) begin
          failures++;
          $display("FAIL frame_start_width got=%b want=0", frame_start_a);
        end
      end
      if (prev_von && !video_on_a) begin
        checks++;
        if (pixel_x_a !== 10'd640) begin
          failures++;
          $display("FAIL video_fall_x got=%0d want=640", pixel_x_a);
        end
      end
      prev_von = video_on_a;
      if (ka >= 4 && ka < 3204) begin
        if (!hsync_a) hs_low++;
        if (video_on_a) von_cnt++;
      end
      if (ka == 3204) begin
        checks++;
        if (pixel_x_a !== 10'd0 || pixel_y_a !== 10'd1) begin
          failures++;
          $display("FAIL line_wrap x=%0d y=%0d want 0 1", pixel_x_a, pixel_y_a);
        end
      end
    end
    checks++;
    if (hs_low != 96 * 4) begin
      failures++;
      $display("FAIL hsync_low_clocks got=%0d want=%0d", hs_low, 96 * 4);
    end
    checks++;
    if (von_cnt != 640 * 4) begin
      failures++;
      $display("FAIL video_on_clocks got=%0d want=%0d", von_cnt, 640 * 4);
    end
  endtask

  task automatic test_midframe_a;
    int n;
    for (n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      if (pixel_x_a == 10'd300 && !p_tick_a) break;
    end
    checks++;
    if (n >= 4000) begin
      failures++;
      $display("FAIL wait_x300 got=timeout want=x300");
    end
    #2 reset_a = 1'b0;
    #1;
    checks++;
    if (obs_a !== RST_A) begin
      failures++;
      $display("FAIL async_reset_a got=%h want=%h", obs_a, RST_A);
    end
    repeat ($urandom_range(1, 4)) @(posedge clk);
    @(negedge clk) reset_a = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_a !== model_a(ka)) begin
        failures++;
        $display("FAIL restart_a k=%0d got=%h want=%h", ka, obs_a, model_a(ka));
      end
    end
  endtask

  task automatic test_frame_b;
    int first_fs, second_fs, von_cnt, vs_low, hs_low;
    first_fs = -1; second_fs = -1; von_cnt = 0; vs_low = 0; hs_low = 0;
    @(negedge clk) reset_b = 1'b1;
    for (int c = 0; c < 700; c++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_b !== model_b(kb)) begin
        failures++;
        $display("FAIL frame_cycle k=%0d got=%h want=%h", kb, obs_b, model_b(kb));
      end
      if (frame_start_b) begin
        if (first_fs < 0) first_fs = kb;
        else if (second_fs < 0) second_fs = kb;
      end
      if (kb >= 2 && kb < 226) begin
        if (video_on_b) von_cnt++;
        if (!vsync_b) vs_low++;
        if (!hsync_b) hs_low++;
      end
    end
    checks++;
    if (first_fs != DB || second_fs != DB + 224) begin
      failures++;
      $display("FAIL frame_period first=%0d second=%0d want %0d %0d", first_fs, second_fs, DB, DB + 224);
    end
    checks++;
    if (von_cnt != HDB * VDB * DB) begin
      failures++;
      $display("FAIL frame_video_clocks got=%0d want=%0d", von_cnt, HDB * VDB * DB);
    end
    checks++;
    if (vs_low != VSB * 14 * DB) begin
      failures++;
      $display("FAIL vsync_low_clocks got=%0d want=%0d", vs_low, VSB * 14 * DB);
    end
    checks++;
    if (hs_low != HSB * 8 * DB) begin
      failures++;
      $display("FAIL hsync_low_small got=%0d want=%0d", hs_low, HSB * 8 * DB);
    end
  endtask

  task automatic test_random_resets_b;
    for (int it = 0; it < 20; it++) begin
      int run_len;
      run_len = $urandom_range(1, 250);
      for (int c = 0; c < run_len; c++) begin
        @(posedge clk); #1;
        checks++;
        if (obs_b !== model_b(kb)) begin
          failures++;
          $display("FAIL rand_run it=%0d k=%0d got=%h want=%h", it, kb, obs_b, model_b(kb));
        end
      end
      #($urandom_range(1, 7)) reset_b = 1'b0;
      #1;
      checks++;
      if (obs_b !== RST_B) begin
        failures++;
        $display("FAIL rand_async_reset it=%0d got=%h want=%h", it, obs_b, RST_B);
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        checks++;
        if (obs_b !== RST_B) begin
          failures++;
          $display("FAIL rand_reset_hold it=%0d got=%h want=%h", it, obs_b, RST_B);
        end
      end
      @(negedge clk) reset_b = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_release_line();
    test_midframe_a();
    test_frame_b();
    test_random_resets_b();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
